// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RV32IM memory stage: load/store over a ready-handshaked data bus
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        in_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [2:0]  funct3,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [4:0]  rd,
  input  logic        reg_write,
  input  logic        flush,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        misaligned,
  output logic        bus_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [4:0]    rd_q, rd_d;
  logic          we_q, we_d, reg_write_q, reg_write_d;
  logic          is_load_q, is_load_d, kill_q, kill_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wb_valid_q, wb_valid_d, wb_reg_write_q, wb_reg_write_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic          misaligned_q, misaligned_d, bus_err_q, bus_err_d;

  logic        is_mem, misal_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in, rshift, load_ext;

  always_comb begin
    is_mem   = mem_read | mem_write;
    misal_in = ((funct3[1:0] == 2'b01) & alu_result[0]) |
               ((funct3[1:0] == 2'b10) & (|alu_result[1:0]));
    case (funct3[1:0])
      2'b00: begin
        be_in    = 4'b0001 << alu_result[1:0];
        wdata_in = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_in    = 4'b0011 << alu_result[1:0];
        wdata_in = {2{store_data[15:0]}};
      end
      default: begin
        be_in    = 4'b1111;
        wdata_in = store_data;
      end
    endcase
    // Lane select uses the latched byte offset, not the word-aligned bus address
    rshift = dmem_rdata >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{rshift[7]}}, rshift[7:0]};
      3'b100:  load_ext = {24'd0, rshift[7:0]};
      3'b001:  load_ext = {{16{rshift[15]}}, rshift[15:0]};
      3'b101:  load_ext = {16'd0, rshift[15:0]};
      default: load_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    be_d           = be_q;
    funct3_d       = funct3_q;
    rd_d           = rd_q;
    we_d           = we_q;
    reg_write_d    = reg_write_q;
    is_load_d      = is_load_q;
    kill_d         = kill_q;
    cnt_d          = cnt_q;
    wb_valid_d     = 1'b0;
    wb_data_d      = 32'd0;
    wb_rd_d        = 5'd0;
    wb_reg_write_d = 1'b0;
    misaligned_d   = 1'b0;
    bus_err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        cnt_d  = '0;
        if (in_valid && !flush) begin
          if (!is_mem) begin
            wb_valid_d     = 1'b1;
            wb_data_d      = alu_result;
            wb_rd_d        = rd;
            wb_reg_write_d = reg_write;
          end else if (misal_in) begin
            misaligned_d = 1'b1;
            wb_valid_d   = 1'b1;
            wb_rd_d      = rd;
          end else begin
            state_d     = BUSY;
            addr_d      = alu_result;
            wdata_d     = wdata_in;
            be_d        = be_in;
            funct3_d    = funct3;
            rd_d        = rd;
            we_d        = mem_write;
            is_load_d   = ~mem_write;
            reg_write_d = reg_write & ~mem_write;
          end
        end
      end
      BUSY: begin
        if (flush) kill_d = 1'b1;
        if (dmem_ready) begin
          state_d        = IDLE;
          cnt_d          = '0;
          kill_d         = 1'b0;
          wb_valid_d     = 1'b1;
          wb_rd_d        = rd_q;
          wb_data_d      = is_load_q ? load_ext : 32'd0;
          wb_reg_write_d = reg_write_q;
        end else if (TO_EN && cnt_q == CNT_LAST) begin
          state_d    = IDLE;
          cnt_d      = '0;
          kill_d     = 1'b0;
          bus_err_d  = 1'b1;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A killed or same-cycle flushed instruction never reaches the register file
    if (flush || (state_q == BUSY && kill_q)) begin
      wb_valid_d     = 1'b0;
      wb_data_d      = 32'd0;
      wb_rd_d        = 5'd0;
      wb_reg_write_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q        <= IDLE;
      addr_q         <= 32'd0;
      wdata_q        <= 32'd0;
      be_q           <= 4'd0;
      funct3_q       <= 3'd0;
      rd_q           <= 5'd0;
      we_q           <= 1'b0;
      reg_write_q    <= 1'b0;
      is_load_q      <= 1'b0;
      kill_q         <= 1'b0;
      cnt_q          <= '0;
      wb_valid_q     <= 1'b0;
      wb_data_q      <= 32'd0;
      wb_rd_q        <= 5'd0;
      wb_reg_write_q <= 1'b0;
      misaligned_q   <= 1'b0;
      bus_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      be_q           <= be_d;
      funct3_q       <= funct3_d;
      rd_q           <= rd_d;
      we_q           <= we_d;
      reg_write_q    <= reg_write_d;
      is_load_q      <= is_load_d;
      kill_q         <= kill_d;
      cnt_q          <= cnt_d;
      wb_valid_q     <= wb_valid_d;
      wb_data_q      <= wb_data_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      misaligned_q   <= misaligned_d;
      bus_err_q      <= bus_err_d;
    end
  end

  assign stall        = (state_q == BUSY);
  assign dmem_req     = (state_q == BUSY);
  assign dmem_we      = we_q & (state_q == BUSY);
  assign dmem_be      = (state_q == BUSY) ? be_q : 4'd0;
  assign dmem_addr    = {addr_q[31:2], 2'b00};
  assign dmem_wdata   = wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_data_q;
  assign wb_rd        = wb_rd_q;
  assign wb_reg_write = wb_reg_write_q;
  assign misaligned   = misaligned_q;
  assign bus_err      = bus_err_q;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the RV32IM pipeline, directly downstream of the execute-stage ALU.
- Consumes the ALU result as the effective address, together with store data and funct3 from EX.
- Runs the load/store over a ready-handshaked data-memory port, with byte-lane alignment, sign/zero extension and misalignment detection.
- Produces the registered writeback record and a stall back to the pipeline while a bus access is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, cycles in BUSY without dmem_ready before abort with bus_err; 0 disables the timeout.

Ports:
CLK  in  1  clock, all state on rising edge
RESET_N  in  1  asynchronous active-low reset
in_valid  in  1  EX result valid this cycle
alu_result  in  32  effective address, or pass-through result for non-memory ops
store_data  in  32  rs2 value for stores
funct3  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
mem_read  in  1  load op
mem_write  in  1  store op
rd  in  5  destination register
reg_write  in  1  op writes rd
flush  in  1  discard the accepted/in-flight instruction's writeback
stall  out  1  upstream must hold EX inputs
dmem_req  out  1  bus request
dmem_we  out  1  write enable
dmem_addr  out  32  word address, {addr[31:2],2'b00}
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables
dmem_ready  in  1  bus completes this cycle; rdata valid
dmem_rdata  in  32  read word
wb_valid  out  1  writeback record valid, 1-cycle pulse per instruction
wb_data  out  32  result to register file
wb_rd  out  5  destination
wb_reg_write  out  1  commit enable
misaligned  out  1  1-cycle pulse, misaligned access detected
bus_err  out  1  1-cycle pulse, timeout abort

Behaviour:
- Reset (RESET_N low, asynchronous): state IDLE; every output 0; timeout counter 0. An outstanding request is dropped; dmem_req falls asynchronously.
- FSM states: IDLE, BUSY.
- Acceptance: an instruction is accepted when in_valid=1 and stall=0.
- stall = (state==BUSY), combinational from state only.
- Non-memory op (mem_read=mem_write=0), IDLE:
  - Next edge: wb_valid=1, wb_data=alu_result, wb_rd=rd, wb_reg_write=reg_write.
  - Latency 1 cycle; back-to-back at 1 per cycle.
- Misalignment:
  - Condition: funct3 H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Next edge: misaligned=1 and wb_valid=1 with wb_reg_write=0.
  - No bus request is issued; stays IDLE.
- Memory op, aligned, IDLE:
  - Next edge: latch address, data, funct3, rd and flags; go BUSY.
  - dmem_req=1 from that cycle. dmem_we=mem_write; dmem_addr is the word address.
- Byte enables:
  - B/BU: 4'b0001 << addr[1:0].
  - H/HU: 4'b0011 << addr[1:0].
  - W: 4'b1111.
- dmem_wdata: B: {4{sd[7:0]}}; H: {2{sd[15:0]}}; W: sd.
- BUSY:
  - dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata are held stable until dmem_ready=1.
  - On the ready edge: go IDLE, drop dmem_req, and register the writeback.
  - wb_valid=1 in the cycle after dmem_ready. stall deasserts in that same cycle, so a new instruction can be accepted then.
- Load data:
  - Select byte/halfword from dmem_rdata by the latched addr[1:0].
  - B/H sign-extend; BU/HU zero-extend; W unchanged.
- Stores: wb_valid=1, wb_reg_write=0, wb_data=0.
- dmem_ready while IDLE is ignored.
- Timeout:
  - Counter increments every BUSY cycle without ready.
  - When it reaches TIMEOUT_CYCLES, next edge: IDLE, dmem_req=0, bus_err pulse, wb_valid=1 with wb_reg_write=0.
  - Counter clears on leaving BUSY.
- Flush:
  - flush=1 in IDLE with an accepting in_valid: the instruction is dropped; no wb_valid, no bus request, no misaligned.
  - flush=1 in BUSY: the bus transaction still completes (never abort a handshake). Set a kill flag; on completion wb_valid=0 and nothing commits. The kill flag clears on IDLE.
  - flush also forces any wb_valid registered on the same edge to 0.
- Simultaneous dmem_ready and timeout expiry in the same cycle: ready wins; normal completion, no bus_err.
- Reset mid-BUSY: abort; no writeback after release. The first post-reset cycle is IDLE and accepts.

Test Plan:
- ALU pass-through: alu_result=0x0000_1234, rd=5, reg_write=1, 3 consecutive cycles -> wb_valid each following cycle, wb_data=0x1234, wb_rd=5, stall never 1.
- LB sign-extend: addr 0x103, dmem_rdata=0x80FF_FF7F, ready after 3 wait cycles -> dmem_be=0001<<3=1000, dmem_addr=0x100, stall 1 for 4 cycles, wb_data=0xFFFF_FF80. Repeat with LBU -> 0x0000_0080.
- SH at 0x202, store_data=0xDEAD_BEEF -> dmem_we=1, dmem_be=1100, dmem_wdata=0xBEEF_BEEF, dmem_addr=0x200, wb_reg_write=0.
- Misaligned LW at 0x301 -> dmem_req stays 0, misaligned pulse, wb_valid=1 with wb_reg_write=0, next instruction accepted immediately.
- TIMEOUT_CYCLES=4, dmem_ready held 0 -> bus_err after 4 BUSY cycles, dmem_req drops. Separately, ready on the expiry cycle -> normal load, bus_err=0.
- Flush during BUSY, then ready -> no wb_valid. RESET_N low mid-BUSY -> dmem_req=0 asynchronously, all outputs 0, clean restart.
